sdram_mem_tester: RTL



---
 rtl/sdram_pkg.sv | 28 ++
 rtl/sdram_lfsr16.sv | 29 ++
 rtl/sdram_mem_tester.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the SDRAM memory tester.
//   - state_e     : tester FSM states
//   - AddrWidth   : controller word-address width (cmd port)
//   - DataWidth   : controller data width (cmd port)
//   - LfsrTaps    : Galois tap mask of the 16-bit pattern LFSR
//   - DefaultSeed : default LFSR seed
//   - lfsr_next() : one right-shift Galois step
package sdram_pkg;

    localparam int          AddrWidth   = 23;
    localparam int          DataWidth   = 16;
    localparam logic [15:0] LfsrTaps    = 16'hB400;
    localparam logic [15:0] DefaultSeed = 16'h0001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ISSUE,
        ST_WR_WAIT,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_DONE
    } state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? LfsrTaps : 16'h0000);
    endfunction

endpackage

// File: rtl/sdram_lfsr16.sv
// sdram_lfsr16: 16-bit Galois LFSR pattern source.
// Ports:
//   clk, rst_ : clock, async active-low reset (value returns to Seed)
//   load      : reload Seed (wins over advance)
//   advance   : step the LFSR once
//   value     : current pattern word
module sdram_lfsr16
    import sdram_pkg::*;
#(
    parameter logic [15:0] Seed = DefaultSeed
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] value
);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            value <= Seed;
        end else if (load) begin
            value <= Seed;
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/sdram_mem_tester.sv
// sdram_mem_tester: writes an LFSR pattern over [StartAddr, EndAddr] through
// the SDRAM controller command port, reads it back and compares.
// Ports:
//   clk, rst_       : clock, async active-low reset
//   start           : one-cycle pulse, starts a test when idle
//   cmdTrigger      : one-cycle command strobe
//   cmdAddr/cmdWrite/cmdWriteData : command fields, held until next trigger
//   cmdReadData     : read data, valid while cmdDone=1 after a read
//   cmdDone         : controller ready (level)
//   busy            : test in progress
//   pass/fail       : sticky result of the last test
//   failAddr        : first mismatching address of the last test
//   errCount        : saturating mismatch count
// Optional: define SDRAM_MEM_TESTER_INVERT_PASS_EN to add a second
// write+read sweep using the inverted pattern.
module sdram_mem_tester
    import sdram_pkg::*;
#(
    parameter int                   AddrWidth     = sdram_pkg::AddrWidth,
    parameter int                   DataWidth     = sdram_pkg::DataWidth,
    parameter logic [AddrWidth-1:0] StartAddr     = '0,
    parameter logic [AddrWidth-1:0] EndAddr       = '1,
    parameter logic [15:0]          Seed          = DefaultSeed,
    parameter int                   ErrCountWidth = 8
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     start,
    output logic                     cmdTrigger,
    output logic [AddrWidth-1:0]     cmdAddr,
    output logic                     cmdWrite,
    output logic [DataWidth-1:0]     cmdWriteData,
    input  logic [DataWidth-1:0]     cmdReadData,
    input  logic                     cmdDone,
    output logic                     busy,
    output logic                     pass,
    output logic                     fail,
    output logic [AddrWidth-1:0]     failAddr,
    output logic [ErrCountWidth-1:0] errCount
);

    // An all-zero seed would lock the LFSR at zero.
    localparam logic [15:0] SeedEff = (Seed == 16'h0000) ? 16'h0001 : Seed;

    state_e                   state, state_d;
    logic [AddrWidth-1:0]     addr, addr_d;
    logic                     trig_d, wr_d, busy_d, pass_d, fail_d;
    logic [AddrWidth-1:0]     cmd_addr_d, fail_addr_d;
    logic [DataWidth-1:0]     wdata_d;
    logic [ErrCountWidth-1:0] err_d;
    logic                     lfsr_load, lfsr_adv;
    logic [15:0]              lfsr, pat;
    logic                     last, mismatch;

    sdram_lfsr16 #(.Seed(SeedEff)) u_lfsr (
        .clk     (clk),
        .rst_    (rst_),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .value   (lfsr)
    );

`ifdef SDRAM_MEM_TESTER_INVERT_PASS_EN
    // Second sweep flag: pattern is ~LFSR while set.
    logic inv, inv_d;
    assign pat = inv ? ~lfsr : lfsr;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) inv <= 1'b0;
        else       inv <= inv_d;
    end
`else
    assign pat = lfsr;
`endif

    assign last     = (addr == EndAddr);
    assign mismatch = (cmdReadData != pat);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state        <= ST_IDLE;
            addr         <= '0;
            cmdTrigger   <= 1'b0;
            cmdAddr      <= '0;
            cmdWrite     <= 1'b0;
            cmdWriteData <= '0;
            busy         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            failAddr     <= '0;
            errCount     <= '0;
        end else begin
            state        <= state_d;
            addr         <= addr_d;
            cmdTrigger   <= trig_d;
            cmdAddr      <= cmd_addr_d;
            cmdWrite     <= wr_d;
            cmdWriteData <= wdata_d;
            busy         <= busy_d;
            pass         <= pass_d;
            fail         <= fail_d;
            failAddr     <= fail_addr_d;
            errCount     <= err_d;
        end
    end

    // In the WAIT states cmdTrigger is still high during the first cycle,
    // which doubles as the holdoff for the controller's registered done.
    always_comb begin
        state_d     = state;
        addr_d      = addr;
        trig_d      = 1'b0;
        cmd_addr_d  = cmdAddr;
        wr_d        = cmdWrite;
        wdata_d     = cmdWriteData;
        busy_d      = busy;
        pass_d      = pass;
        fail_d      = fail;
        fail_addr_d = failAddr;
        err_d       = errCount;
        lfsr_load   = 1'b0;
        lfsr_adv    = 1'b0;
`ifdef SDRAM_MEM_TESTER_INVERT_PASS_EN
        inv_d       = inv;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                    err_d       = '0;
                    fail_addr_d = '0;
                    addr_d      = StartAddr;
                    lfsr_load   = 1'b1;
                    busy_d      = 1'b1;
`ifdef SDRAM_MEM_TESTER_INVERT_PASS_EN
                    inv_d       = 1'b0;
`endif
                    state_d     = ST_WR_ISSUE;
                end
            end
            ST_WR_ISSUE: begin
                if (cmdDone) begin
                    trig_d     = 1'b1;
                    wr_d       = 1'b1;
                    cmd_addr_d = addr;
                    wdata_d    = pat;
                    state_d    = ST_WR_WAIT;
                end
            end
            ST_WR_WAIT: begin
                if (!cmdTrigger && cmdDone) begin
                    if (last) begin
                        addr_d    = StartAddr;
                        lfsr_load = 1'b1;
                        state_d   = ST_RD_ISSUE;
                    end else begin
                        addr_d    = addr + 1'b1;
                        lfsr_adv  = 1'b1;
                        state_d   = ST_WR_ISSUE;
                    end
                end
            end
            ST_RD_ISSUE: begin
                if (cmdDone) begin
                    trig_d     = 1'b1;
                    wr_d       = 1'b0;
                    cmd_addr_d = addr;
                    state_d    = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (!cmdTrigger && cmdDone) begin
                    if (mismatch) begin
                        if (!fail) fail_addr_d = addr;
                        fail_d = 1'b1;
                        if (errCount != '1) err_d = errCount + 1'b1;
                    end
                    // Compare happens before the increment, so an EndAddr
                    // at the top of the address space never wraps.
                    if (last) begin
`ifdef SDRAM_MEM_TESTER_INVERT_PASS_EN
                        if (!inv) begin
                            inv_d     = 1'b1;
                            addr_d    = StartAddr;
                            lfsr_load = 1'b1;
                            state_d   = ST_WR_ISSUE;
                        end else begin
                            state_d   = ST_DONE;
                        end
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        addr_d   = addr + 1'b1;
                        lfsr_adv = 1'b1;
                        state_d  = ST_RD_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                pass_d  = ~fail;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
